// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM encodings and
// the bit-counter width helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counter must index bits 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/half_adder.sv
// One-bit half adder cell, the building block of the serial full-add stage.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: accepts operands on a valid/ready handshake,
// adds one bit per clock LSB-first, and presents sum and carry on a result handshake.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             busy
);

  import serial_add_pkg::*;

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic s1, c1, s, c2;

  // Full add built from two half adders; the carries can never both be set.
  half_adder ha0 (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .sum   (s1),
    .carry (c1)
  );

  half_adder ha1 (
    .a     (s1),
    .b     (carry_q),
    .sum   (s),
    .carry (c2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid)           state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == CNT_LAST)  state_d = ST_DONE;
      ST_DONE:  if (out_ready)          state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    if (state_q == ST_IDLE && in_valid) begin
      a_d      = a_in;
      b_d      = b_in;
      result_d = '0;
      carry_d  = 1'b0;
      cnt_d    = '0;
    end else if (state_q == ST_SHIFT) begin
      a_d      = a_q >> 1;
      b_d      = b_q >> 1;
      result_d = {s, result_q[WIDTH-1:1]};
      carry_d  = c1 | c2;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sum_out   = result_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed vector table
// plus hand-written reset, backpressure and back-to-back sequences.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_sum;
    logic       exp_carry;
  } vec_t;

  vec_t vecs[8];

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .carry_out (carry_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands, wait for the accept edge, then count edges until out_valid.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic rdy, output int lat);
    @(negedge clk);
    a_in      = a;
    b_in      = b;
    in_valid  = 1'b1;
    out_ready = rdy;
    checkOutput("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) begin
      errors++;
      checks++;
      $display("[TB] FAIL timeout_waiting_out_valid: got 0 expected 1");
    end
  endtask

  initial begin
    int lat;
    int acc_cyc;
    int prev_acc;
    int wait_n;
    logic [8:0] ref_val;
    logic [7:0] pa [4];
    logic [7:0] pb [4];
    bit seen_valid;

    vecs[0] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[1] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
    vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{8'h12, 8'h34, 8'h46, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[6] = '{8'hC8, 8'h64, 8'h2C, 1'b1};
    vecs[7] = '{8'h0F, 8'h01, 8'h10, 1'b0};

    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;
    rst       = 1'b0;

    // Asynchronous reset asserted mid-clock, checked before any edge.
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_in_ready",  {31'd0, in_ready},  32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_busy",      {31'd0, busy},      32'd0);
    checkOutput("rst_sum",       {24'd0, sum_out},   32'd0);
    checkOutput("rst_carry",     {31'd0, carry_out}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, 1'b1, lat);
      checkOutput($sformatf("vec%0d_latency", i), lat, 32'd8);
      checkOutput($sformatf("vec%0d_sum", i), {24'd0, sum_out}, {24'd0, vecs[i].exp_sum});
      checkOutput($sformatf("vec%0d_carry", i), {31'd0, carry_out}, {31'd0, vecs[i].exp_carry});
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_valid_pulse", i), {31'd0, out_valid}, 32'd0);
      checkOutput($sformatf("vec%0d_idle_ready", i), {31'd0, in_ready}, 32'd1);
      checkOutput($sformatf("vec%0d_sum_kept", i), {24'd0, sum_out}, {24'd0, vecs[i].exp_sum});
    end

    $display("[TB] backpressure");
    applyStimulus(8'h3C, 8'h0F, 1'b0, lat);
    checkOutput("bp_latency", lat, 32'd8);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      a_in     = 8'h11;
      checkOutput($sformatf("bp%0d_valid", k), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("bp%0d_sum", k),   {24'd0, sum_out},   32'h4B);
      checkOutput($sformatf("bp%0d_carry", k), {31'd0, carry_out}, 32'd0);
      checkOutput($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_release_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("bp_no_accept_busy", {31'd0, busy}, 32'd0);
    checkOutput("bp_sum_kept", {24'd0, sum_out}, 32'h4B);

    $display("[TB] reset during shift");
    a_in     = 8'h12;
    b_in     = 8'h34;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    checkOutput("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_rst_sum",       {24'd0, sum_out},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    checkOutput("mid_rst_never_valid", {31'd0, seen_valid}, 32'd0);
    applyStimulus(8'h7F, 8'h01, 1'b1, lat);
    checkOutput("post_rst_latency", lat, 32'd8);
    checkOutput("post_rst_sum",   {24'd0, sum_out},   32'h80);
    checkOutput("post_rst_carry", {31'd0, carry_out}, 32'd0);
    @(posedge clk);
    @(negedge clk);

    $display("[TB] back-to-back");
    for (int k = 0; k < 4; k++) begin
      pa[k] = 8'($urandom_range(0, 255));
      pb[k] = 8'($urandom_range(0, 255));
    end
    prev_acc = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    a_in = pa[0];
    b_in = pb[0];
    for (int k = 0; k < 4; k++) begin
      wait_n = 0;
      while (!in_ready && wait_n < 40) begin
        @(negedge clk);
        wait_n++;
      end
      if (!in_ready) begin
        errors++;
        checks++;
        $display("[TB] FAIL b2b%0d_timeout_in_ready: got 0 expected 1", k);
      end
      @(posedge clk);
      @(negedge clk);
      acc_cyc = cyc;
      if (k > 0)
        checkOutput($sformatf("b2b%0d_spacing", k), acc_cyc - prev_acc, WIDTH + 2);
      prev_acc = acc_cyc;
      if (k < 3) begin
        a_in = pa[k+1];
        b_in = pb[k+1];
      end
      wait_n = 0;
      while (!out_valid && wait_n < 40) begin
        @(negedge clk);
        wait_n++;
      end
      ref_val = {1'b0, pa[k]} + {1'b0, pb[k]};
      checkOutput($sformatf("b2b%0d_sum", k), {24'd0, sum_out}, {24'd0, ref_val[7:0]});
      checkOutput($sformatf("b2b%0d_carry", k), {31'd0, carry_out}, {31'd0, ref_val[8]});
      if (k == 3) in_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("b2b_final_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
